// File: rtl/filterbank_sequencer_if.sv
// Sample-in / band-out handshake bundle for the filterbank sequencer.
// master = upstream/downstream side, slave = sequencer.
interface filterbank_sequencer_if;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;

   modport master (
      output in_valid,
      input  in_ready,
      input  out_valid,
      output out_ready
   );

   modport slave (
      input  in_valid,
      output in_ready,
      output out_valid,
      input  out_ready
   );
endinterface

// File: rtl/filterbank_sequencer.sv
// Sequencer for the 16-band serial filterbank: accept, shift,
// step the shared MAC through symmetric tap pairs, then dump.
module filterbank_sequencer #(
   parameter int NUM_PHASES = 60,
   parameter int NUM_TAPS   = 119,
   parameter int PHASE_W    = 6,
   parameter int TAP_W      = 7,
   parameter int CNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clk_enable,
   filterbank_sequencer_if.slave hs,
   output logic               shift_en,
   output logic               mac_en,
   output logic               acc_clear,
   output logic [PHASE_W-1:0] phase,
   output logic               phase_last,
   output logic [TAP_W-1:0]   tap_lo,
   output logic [TAP_W-1:0]   tap_hi,
   output logic               busy,
   output logic [CNT_W-1:0]   sample_cnt
);

   localparam logic [PHASE_W-1:0] PH_LAST =
      PHASE_W'(NUM_PHASES - 1);
   localparam logic [TAP_W-1:0] TAP_MAX =
      TAP_W'(NUM_TAPS - 1);

   typedef enum logic [1:0] {
      IDLE, SHIFT, RUN, DUMP
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [PHASE_W-1:0] phase_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   // State, phase and frame counter registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         phase      <= '0;
         sample_cnt <= '0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         sample_cnt <= cnt_nxt;
      end
   end

   // Next state; nothing moves while clk_enable is low
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      cnt_nxt   = sample_cnt;
      if (clk_enable) begin
         unique case (state)
            IDLE: begin
               if (hs.in_valid)
                  state_nxt = SHIFT;
            end
            SHIFT: begin
               state_nxt = RUN;
               phase_nxt = '0;
            end
            RUN: begin
               if (phase == PH_LAST) begin
                  state_nxt = DUMP;
                  phase_nxt = '0;
               end else begin
                  phase_nxt = phase + PHASE_W'(1);
               end
            end
            DUMP: begin
               if (hs.out_ready) begin
                  state_nxt = IDLE;
                  cnt_nxt   = sample_cnt + CNT_W'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Strobes and tap addresses decoded from registered state
   always_comb begin
      hs.in_ready  = (state == IDLE) & clk_enable & ~reset;
      hs.out_valid = (state == DUMP);
      shift_en     = (state == SHIFT) & clk_enable;
      mac_en       = (state == RUN) & clk_enable;
      acc_clear    = mac_en & (phase == '0);
      phase_last   = (phase == PH_LAST);
      busy         = (state != IDLE);
      tap_lo       = TAP_W'(phase);
      tap_hi       = TAP_MAX - TAP_W'(phase);
   end

endmodule
